axi_wr_arbiter_2m: RTL and testbench
====================================

# axi_wr_arbiter_2m

Two-master AXI3 write-path arbiter that lets two bus-functional or RTL masters share one AXI slave write port. It arbitrates AW requests round-robin, holds the grant from address acceptance through the WLAST beat, and routes B responses back using a master-index bit prepended to the transaction ID. It sits between the AXI masters (e.g. the test-bench BFMs) and a single memory or slave model; read channels are not handled.

## Interface
- WIDTH_ID, 4, master-side ID width; slave-side ID width is WIDTH_ID+1.
- WIDTH_AD, 32, address width.
- WIDTH_DA, 32, data width.
- WIDTH_DS, WIDTH_DA/8, strobe width.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- M0_/M1_ AWID in WIDTH_ID, AWADDR in WIDTH_AD, AWLEN in 4, AWLOCK in 2, AWSIZE in 3, AWBURST in 2, AWVALID in 1, AWREADY out 1: per-master AW channel.
- M0_/M1_ WID in WIDTH_ID, WDATA in WIDTH_DA, WSTRB in WIDTH_DS, WLAST in 1, WVALID in 1, WREADY out 1: per-master W channel.
- M0_/M1_ BID out WIDTH_ID, BRESP out 2, BVALID out 1, BREADY in 1: per-master B channel.
- S_AWID out WIDTH_ID+1, S_AWADDR/AWLEN/AWLOCK/AWSIZE/AWBURST out (widths as above), S_AWVALID out 1, S_AWREADY in 1.
- S_WID out WIDTH_ID+1, S_WDATA out WIDTH_DA, S_WSTRB out WIDTH_DS, S_WLAST out 1, S_WVALID out 1, S_WREADY in 1.
- S_BID in WIDTH_ID+1, S_BRESP in 2, S_BVALID in 1, S_BREADY out 1.

## Operation
- State machine on registered `state`: IDLE, ADDR, DATA. Registered `gnt` (0/1) and `last` (last granted master).
- IDLE: if neither Mx_AWVALID, stay. If one asserts, gnt<=that master. If both, gnt<=~last. Go to ADDR; last<=new gnt.
- ADDR: S_AW* = Mgnt_AW* with S_AWID={gnt, Mgnt_AWID}; S_AWVALID=Mgnt_AWVALID; Mgnt_AWREADY=S_AWREADY; other master AWREADY=0. On S_AWVALID&S_AWREADY -> DATA. If granted master drops AWVALID (protocol violation) stay in ADDR.
- DATA: S_W* = Mgnt_W*, S_WID={gnt, Mgnt_WID}; S_WVALID=Mgnt_WVALID; Mgnt_WREADY=S_WREADY; other WREADY=0. On S_WVALID&S_WREADY&S_WLAST -> IDLE. Beat count is not checked; WLAST alone terminates.
- W from any master outside DATA is not accepted (WREADY=0); masters must issue AW before or with W.
- B routing is stateless and independent of `state`: S_BID[WIDTH_ID] selects master; Mx_BID=S_BID[WIDTH_ID-1:0]; Mx_BRESP=S_BRESP; Mx_BVALID=S_BVALID when selected; S_BREADY=Mselected_BREADY. Unselected master BVALID=0.
- In IDLE, S_AWVALID=S_WVALID=0; S_AW*/S_W* payload outputs follow master 0 (don't-care).

## Timing
- Reset (asynchronous on ARESET rise, held while high): state=IDLE, gnt=0, last=1 (so M0 wins the first tie). All VALID/READY outputs 0 during reset; payload outputs don't-care.
- Reset mid-burst: burst abandoned immediately; no further beats forwarded; slave recovery is the slave's own reset responsibility.
- Arbitration latency: AWVALID seen in IDLE at edge t -> S_AWVALID high after edge t (cycle t+1).
- Handshakes combinational through the mux in ADDR/DATA; no added pipeline delay on AW/W/B.
- Burst of N beats with zero-wait slave: 1 (IDLE) + 1 (AW) + N cycles; minimum one IDLE cycle between consecutive bursts.
- B response may complete in any state, including concurrently with AW or W handshakes of another burst.

## Test plan
- Single master: M0 writes AWADDR=0x30, AWLEN=3, AWID=7, four beats -> S_AWID=0x07, S_WID=0x07, four S_W beats, S_WLAST on 4th; B with S_BID=0x07 appears only on M0, M1_BVALID=0.
- Tie: M0 and M1 raise AWVALID in same cycle after reset -> M0 granted first (S_AWID[4]=0), then M1 (S_AWID[4]=1) after M0 WLAST; next tie grants M0 again (alternation).
- Back-pressure: S_AWREADY low 3 cycles, S_WREADY toggling -> state holds ADDR/DATA, no beat lost or duplicated, M1_WREADY stays 0 throughout M0 burst.
- Early W: M1 asserts WVALID while M0 owns the bus -> M1_WREADY=0 until M1 granted and AW accepted.
- B concurrency: S_BVALID with S_BID=0x13 during M0 data burst -> M1_BVALID=1, M1_BID=0x3, S_BREADY follows M1_BREADY; M0 burst unaffected.
- Reset in DATA after 2 of 4 beats -> all VALID/READY 0 immediately, state IDLE, next request from M1 alone granted normally.

Source files
------------

// File: rtl/axi_wr_arbiter_2m.sv
// Two-master AXI3 write arbiter: round-robin AW grant held through WLAST,
// B responses steered back by the master-index bit prepended to the ID.
module axi_wr_arbiter_2m #(
  parameter int WIDTH_ID = 4,
  parameter int WIDTH_AD = 32,
  parameter int WIDTH_DA = 32,
  parameter int WIDTH_DS = WIDTH_DA / 8
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [WIDTH_ID-1:0] M0_AWID,
  input  logic [WIDTH_AD-1:0] M0_AWADDR,
  input  logic [3:0]          M0_AWLEN,
  input  logic [1:0]          M0_AWLOCK,
  input  logic [2:0]          M0_AWSIZE,
  input  logic [1:0]          M0_AWBURST,
  input  logic                M0_AWVALID,
  output logic                M0_AWREADY,
  input  logic [WIDTH_ID-1:0] M0_WID,
  input  logic [WIDTH_DA-1:0] M0_WDATA,
  input  logic [WIDTH_DS-1:0] M0_WSTRB,
  input  logic                M0_WLAST,
  input  logic                M0_WVALID,
  output logic                M0_WREADY,
  output logic [WIDTH_ID-1:0] M0_BID,
  output logic [1:0]          M0_BRESP,
  output logic                M0_BVALID,
  input  logic                M0_BREADY,
  input  logic [WIDTH_ID-1:0] M1_AWID,
  input  logic [WIDTH_AD-1:0] M1_AWADDR,
  input  logic [3:0]          M1_AWLEN,
  input  logic [1:0]          M1_AWLOCK,
  input  logic [2:0]          M1_AWSIZE,
  input  logic [1:0]          M1_AWBURST,
  input  logic                M1_AWVALID,
  output logic                M1_AWREADY,
  input  logic [WIDTH_ID-1:0] M1_WID,
  input  logic [WIDTH_DA-1:0] M1_WDATA,
  input  logic [WIDTH_DS-1:0] M1_WSTRB,
  input  logic                M1_WLAST,
  input  logic                M1_WVALID,
  output logic                M1_WREADY,
  output logic [WIDTH_ID-1:0] M1_BID,
  output logic [1:0]          M1_BRESP,
  output logic                M1_BVALID,
  input  logic                M1_BREADY,
  output logic [WIDTH_ID:0]   S_AWID,
  output logic [WIDTH_AD-1:0] S_AWADDR,
  output logic [3:0]          S_AWLEN,
  output logic [1:0]          S_AWLOCK,
  output logic [2:0]          S_AWSIZE,
  output logic [1:0]          S_AWBURST,
  output logic                S_AWVALID,
  input  logic                S_AWREADY,
  output logic [WIDTH_ID:0]   S_WID,
  output logic [WIDTH_DA-1:0] S_WDATA,
  output logic [WIDTH_DS-1:0] S_WSTRB,
  output logic                S_WLAST,
  output logic                S_WVALID,
  input  logic                S_WREADY,
  input  logic [WIDTH_ID:0]   S_BID,
  input  logic [1:0]          S_BRESP,
  input  logic                S_BVALID,
  output logic                S_BREADY
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t state;
  logic   gnt;
  logic   last;
  logic   next_gnt;
  logic   sel;
  logic   in_addr;
  logic   in_data;
  logic   bsel;

  // Alternate only on a true tie; a lone requester always wins.
  assign next_gnt = (M0_AWVALID && M1_AWVALID) ? ~last : M1_AWVALID;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state <= IDLE;
      gnt   <= 1'b0;
      last  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (M0_AWVALID || M1_AWVALID) begin
            gnt   <= next_gnt;
            last  <= next_gnt;
            state <= ADDR;
          end
        end
        ADDR: if (S_AWVALID && S_AWREADY) state <= DATA;
        DATA: if (S_WVALID && S_WREADY && S_WLAST) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Payload mux follows master 0 while idle so the slave sees stable values.
  assign sel     = (state == IDLE) ? 1'b0 : gnt;
  assign in_addr = (state == ADDR);
  assign in_data = (state == DATA);

  assign S_AWID    = {sel, sel ? M1_AWID : M0_AWID};
  assign S_AWADDR  = sel ? M1_AWADDR  : M0_AWADDR;
  assign S_AWLEN   = sel ? M1_AWLEN   : M0_AWLEN;
  assign S_AWLOCK  = sel ? M1_AWLOCK  : M0_AWLOCK;
  assign S_AWSIZE  = sel ? M1_AWSIZE  : M0_AWSIZE;
  assign S_AWBURST = sel ? M1_AWBURST : M0_AWBURST;
  assign S_AWVALID = in_addr && (sel ? M1_AWVALID : M0_AWVALID);
  assign M0_AWREADY = in_addr && !sel && S_AWREADY;
  assign M1_AWREADY = in_addr &&  sel && S_AWREADY;

  assign S_WID    = {sel, sel ? M1_WID : M0_WID};
  assign S_WDATA  = sel ? M1_WDATA : M0_WDATA;
  assign S_WSTRB  = sel ? M1_WSTRB : M0_WSTRB;
  assign S_WLAST  = sel ? M1_WLAST : M0_WLAST;
  assign S_WVALID = in_data && (sel ? M1_WVALID : M0_WVALID);
  assign M0_WREADY = in_data && !sel && S_WREADY;
  assign M1_WREADY = in_data &&  sel && S_WREADY;

  // B path is stateless; only reset suppresses the handshake.
  assign bsel      = S_BID[WIDTH_ID];
  assign M0_BID    = S_BID[WIDTH_ID-1:0];
  assign M1_BID    = S_BID[WIDTH_ID-1:0];
  assign M0_BRESP  = S_BRESP;
  assign M1_BRESP  = S_BRESP;
  assign M0_BVALID = !ARESET && S_BVALID && !bsel;
  assign M1_BVALID = !ARESET && S_BVALID &&  bsel;
  assign S_BREADY  = !ARESET && (bsel ? M1_BREADY : M0_BREADY);

endmodule

// File: tb/tb_axi_wr_arbiter_2m.sv
// Randomized bench for axi_wr_arbiter_2m checked every cycle against a
// bus-ownership reference model.
module tb_axi_wr_arbiter_2m;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]  awid[2];
  logic [31:0] awaddr[2];
  logic [3:0]  awlen[2];
  logic [1:0]  awlock[2];
  logic [2:0]  awsize[2];
  logic [1:0]  awburst[2];
  logic        awvalid[2];
  logic        awready[2];
  logic [3:0]  wid[2];
  logic [31:0] wdata[2];
  logic [3:0]  wstrb[2];
  logic        wlast[2];
  logic        wvalid[2];
  logic        wready[2];
  logic [3:0]  bid[2];
  logic [1:0]  bresp[2];
  logic        bvalid[2];
  logic        bready[2];

  logic [4:0]  s_awid;
  logic [31:0] s_awaddr;
  logic [3:0]  s_awlen;
  logic [1:0]  s_awlock;
  logic [2:0]  s_awsize;
  logic [1:0]  s_awburst;
  logic        s_awvalid;
  logic        s_awready;
  logic [4:0]  s_wid;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wlast;
  logic        s_wvalid;
  logic        s_wready;
  logic [4:0]  s_bid;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready;

  axi_wr_arbiter_2m dut (
    .ACLK(clk), .ARESET(rst),
    .M0_AWID(awid[0]), .M0_AWADDR(awaddr[0]), .M0_AWLEN(awlen[0]), .M0_AWLOCK(awlock[0]),
    .M0_AWSIZE(awsize[0]), .M0_AWBURST(awburst[0]), .M0_AWVALID(awvalid[0]), .M0_AWREADY(awready[0]),
    .M0_WID(wid[0]), .M0_WDATA(wdata[0]), .M0_WSTRB(wstrb[0]), .M0_WLAST(wlast[0]),
    .M0_WVALID(wvalid[0]), .M0_WREADY(wready[0]),
    .M0_BID(bid[0]), .M0_BRESP(bresp[0]), .M0_BVALID(bvalid[0]), .M0_BREADY(bready[0]),
    .M1_AWID(awid[1]), .M1_AWADDR(awaddr[1]), .M1_AWLEN(awlen[1]), .M1_AWLOCK(awlock[1]),
    .M1_AWSIZE(awsize[1]), .M1_AWBURST(awburst[1]), .M1_AWVALID(awvalid[1]), .M1_AWREADY(awready[1]),
    .M1_WID(wid[1]), .M1_WDATA(wdata[1]), .M1_WSTRB(wstrb[1]), .M1_WLAST(wlast[1]),
    .M1_WVALID(wvalid[1]), .M1_WREADY(wready[1]),
    .M1_BID(bid[1]), .M1_BRESP(bresp[1]), .M1_BVALID(bvalid[1]), .M1_BREADY(bready[1]),
    .S_AWID(s_awid), .S_AWADDR(s_awaddr), .S_AWLEN(s_awlen), .S_AWLOCK(s_awlock),
    .S_AWSIZE(s_awsize), .S_AWBURST(s_awburst), .S_AWVALID(s_awvalid), .S_AWREADY(s_awready),
    .S_WID(s_wid), .S_WDATA(s_wdata), .S_WSTRB(s_wstrb), .S_WLAST(s_wlast),
    .S_WVALID(s_wvalid), .S_WREADY(s_wready),
    .S_BID(s_bid), .S_BRESP(s_bresp), .S_BVALID(s_bvalid), .S_BREADY(s_bready)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: who owns the bus (-1 = free), whether its address
  // has been accepted, and who won the previous arbitration.
  int owner    = -1;
  bit aw_done  = 1'b0;
  int prev_win = 1;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    else
      n_pass++;
  endtask

  task automatic check_outputs(input bit in_rst);
    bit   owned, addr_ph, data_ph, live;
    int   m;
    logic mb, bs;
    owned   = !in_rst && (owner >= 0);
    addr_ph = owned && !aw_done;
    data_ph = owned && aw_done;
    m       = owned ? owner : 0;
    mb      = m[0];
    live    = !in_rst;
    bs      = s_bid[4];

    check_val("s_awvalid", 64'(s_awvalid), 64'(addr_ph && awvalid[m]));
    check_val("m_awready", 64'({awready[0], awready[1]}),
              64'({addr_ph && m == 0 && s_awready, addr_ph && m == 1 && s_awready}));
    if (addr_ph)
      check_val("s_aw_payload",
                64'({s_awid, s_awaddr, s_awlen, s_awlock, s_awsize, s_awburst}),
                64'({mb, awid[m], awaddr[m], awlen[m], awlock[m], awsize[m], awburst[m]}));

    check_val("s_wvalid", 64'(s_wvalid), 64'(data_ph && wvalid[m]));
    check_val("m_wready", 64'({wready[0], wready[1]}),
              64'({data_ph && m == 0 && s_wready, data_ph && m == 1 && s_wready}));
    if (data_ph)
      check_val("s_w_payload", 64'({s_wid, s_wdata, s_wstrb, s_wlast}),
                64'({mb, wid[m], wdata[m], wstrb[m], wlast[m]}));

    check_val("m_bvalid", 64'({bvalid[0], bvalid[1]}),
              64'({live && s_bvalid && !bs, live && s_bvalid && bs}));
    check_val("s_bready", 64'(s_bready), 64'(live && (bs ? bready[1] : bready[0])));
    check_val("m_b_payload", 64'({bid[0], bresp[0], bid[1], bresp[1]}),
              64'({s_bid[3:0], s_bresp, s_bid[3:0], s_bresp}));
  endtask

  task automatic model_step;
    int w;
    if (rst) begin
      owner = -1; aw_done = 1'b0; prev_win = 1;
    end else if (owner < 0) begin
      if (awvalid[0] || awvalid[1]) begin
        w = (awvalid[0] && awvalid[1]) ? 1 - prev_win : (awvalid[1] ? 1 : 0);
        owner = w; prev_win = w; aw_done = 1'b0;
      end
    end else if (!aw_done) begin
      if (awvalid[owner] && s_awready) aw_done = 1'b1;
    end else if (wvalid[owner] && s_wready && wlast[owner]) begin
      $display("burst done: master %0d at t=%0t", owner, $time);
      owner = -1;
    end
  endtask

  task automatic randomize_inputs;
    for (int i = 0; i < 2; i++) begin
      awid[i]    = 4'($urandom);
      awaddr[i]  = $urandom;
      awlen[i]   = 4'($urandom);
      awlock[i]  = 2'($urandom);
      awsize[i]  = 3'($urandom);
      awburst[i] = 2'($urandom);
      awvalid[i] = ($urandom_range(0, 1) == 1);
      wid[i]     = 4'($urandom);
      wdata[i]   = $urandom;
      wstrb[i]   = 4'($urandom);
      wlast[i]   = ($urandom_range(0, 3) == 0);
      wvalid[i]  = ($urandom_range(0, 4) < 3);
      bready[i]  = ($urandom_range(0, 1) == 1);
    end
    s_awready = ($urandom_range(0, 4) < 3);
    s_wready  = ($urandom_range(0, 4) < 3);
    s_bid     = 5'($urandom);
    s_bresp   = 2'($urandom);
    s_bvalid  = ($urandom_range(0, 4) < 2);
  endtask

  initial begin
    randomize_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs(1'b1);
    @(posedge clk);
    model_step();
    #1;
    rst = 1'b0;
    randomize_inputs();
    awvalid[0] = 1'b1;
    awvalid[1] = 1'b1;

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      check_outputs(rst);
      @(posedge clk);
      model_step();
      #1;
      randomize_inputs();
      if (rst) begin
        rst = 1'b0;
      end else if ($urandom_range(0, 79) == 0) begin
        // Mid-cycle reset: outputs must collapse without waiting for a clock edge.
        #1 rst = 1'b1;
        #1 check_outputs(1'b1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
